alu_issue_ctrl: RTL and testbench

- Sequential issue/writeback controller wrapped around the team's combinational 4-bit ALU.
- Accepts one ALU command per handshake and reads operands from a small internal register file or an immediate.
- Drives registered sel/A/B into the ALU, then captures the ALU result and flags.
- Writes the result back to the destination register and presents it on a valid/ready output port.

---
 rtl/alu_issue_ctrl.sv | 125 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller around the combinational ALU: accepts one command,
// drives registered ALU inputs, captures result and flags, writes back and presents it.
module alu_issue_ctrl #(
  parameter int DATA_W   = 4,
  parameter int NUM_REGS = 4,
  parameter int REG_AW   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  output logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  input  logic              alu_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   rf_q [NUM_REGS];
  logic [2:0]          sel_q;
  logic [DATA_W-1:0]   a_q, b_q, data_q;
  logic [REG_AW-1:0]   rd_q, out_rd_q;
  logic                z_q, c_q, v_q;
  logic                accept, exec;
  logic [DATA_W-1:0]   rs1_val, rs2_val;

  // r0 is hard zero on every read port regardless of the storage behind it
  assign rs1_val  = (in_rs1   == '0) ? '0 : rf_q[in_rs1];
  assign rs2_val  = (in_rs2   == '0) ? '0 : rf_q[in_rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  assign accept = in_valid && in_ready;
  assign exec   = (state_q == EXEC);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      EXEC: state_d = WB;
      WB: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
    end else if (accept) begin
      sel_q <= in_op;
      a_q   <= rs1_val;
      b_q   <= in_imm_en ? in_imm : rs2_val;
      rd_q  <= in_rd;
    end
  end

  // Carry/overflow only carry meaning for add/sub; other ops clear them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      out_rd_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else if (exec) begin
      data_q   <= alu_result;
      out_rd_q <= rd_q;
      z_q      <= (alu_result == '0);
      c_q      <= (sel_q[2:1] == 2'b00) ? alu_carry    : 1'b0;
      v_q      <= (sel_q[2:1] == 2'b00) ? alu_overflow : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (exec && (rd_q != '0)) begin
      rf_q[rd_q] <= alu_result;
    end
  end

  assign alu_sel  = sel_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign out_data = data_q;
  assign out_rd   = out_rd_q;
  assign flag_z   = z_q;
  assign flag_c   = c_q;
  assign flag_v   = v_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed plus randomized bench for alu_issue_ctrl with a bit-level ALU stub
// and an integer-arithmetic reference model of the register file and flags.
module tb_alu_issue_ctrl;

  logic       clk, rst_n;
  logic       in_valid, in_ready;
  logic [2:0] in_op;
  logic [1:0] in_rd, in_rs1, in_rs2;
  logic       in_imm_en;
  logic [3:0] in_imm;
  logic [2:0] alu_sel;
  logic [3:0] alu_a, alu_b, alu_result;
  logic       alu_overflow, alu_carry;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic [1:0] out_rd;
  logic       flag_z, flag_c, flag_v;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
  logic [4:0] alu_s;

  int ncmp = 0;
  int nfail = 0;
  int m_reg [4];
  int m_z, m_c, m_v;

  alu_issue_ctrl #(.DATA_W(4), .NUM_REGS(4), .REG_AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd),
    .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in; logic ops emit junk carry/overflow so the controller's clearing is visible
  always_comb begin
    alu_s        = '0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_sel)
      3'd0: begin
        alu_s = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_s[3:0]; alu_carry = alu_s[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_s[3] != alu_a[3]);
      end
      3'd1: begin
        alu_s = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_s[3:0]; alu_carry = alu_s[4];
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_s[3] != alu_a[3]);
      end
      3'd2: begin alu_result = ~alu_a;         alu_carry = alu_a[0]; alu_overflow = 1'b1; end
      3'd3: begin alu_result = alu_a & alu_b;  alu_carry = 1'b1;     alu_overflow = alu_b[0]; end
      3'd4: begin alu_result = alu_a | alu_b;  alu_carry = alu_a[1]; alu_overflow = 1'b1; end
      3'd5: begin alu_result = alu_a ^ alu_b;  alu_carry = 1'b1;     alu_overflow = 1'b1; end
      3'd6: begin alu_result = {3'b0, $signed(alu_a) < $signed(alu_b)}; alu_carry = 1'b1; end
      default: begin alu_result = {3'b0, alu_a == alu_b}; alu_overflow = 1'b1; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic: r result, c borrow/carry-out, v signed overflow
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int c, output int v);
    int sa, sb, t;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    c = 0; v = 0; r = 0;
    case (op)
      0: begin t = a + b; r = t % 16; c = int'(t > 15); t = sa + sb; v = int'(t > 7 || t < -8); end
      1: begin t = a - b; r = (t + 16) % 16; c = int'(a < b); t = sa - sb; v = int'(t > 7 || t < -8); end
      2: r = 15 - a;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = int'(sa < sb);
      default: r = int'(a == b);
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < 4; k++) begin
      dbg_addr = 2'(k);
      #1;
      chk($sformatf("%s_r%0d", tag, k), {28'b0, dbg_data}, m_reg[k]);
    end
  endtask

  task automatic do_cmd(input int op, input int rd, input int rs1, input int rs2,
                        input int ie, input int imm, input int hold);
    int a, b, r, c, v, n;
    n = 0;
    while (!in_ready && n < 10) begin @(posedge clk); #1; n++; end
    chk("ready_wait", {31'b0, in_ready}, 1);
    in_valid = 1'b1; in_op = 3'(op); in_rd = 2'(rd); in_rs1 = 2'(rs1); in_rs2 = 2'(rs2);
    in_imm_en = ie[0]; in_imm = 4'(imm);
    a = m_reg[rs1];
    b = ie ? imm : m_reg[rs2];
    ref_alu(op, a, b, r, c, v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_rs1 = 2'($urandom); in_rs2 = 2'($urandom); in_imm = 4'($urandom);
    chk("exec_out_valid", {31'b0, out_valid}, 0);
    chk("exec_in_ready", {31'b0, in_ready}, 0);
    chk("alu_sel", {29'b0, alu_sel}, op);
    chk("alu_a", {28'b0, alu_a}, a);
    chk("alu_b", {28'b0, alu_b}, b);
    @(posedge clk); #1;
    if (rd != 0) m_reg[rd] = r;
    m_z = int'(r == 0);
    m_c = (op < 2) ? c : 0;
    m_v = (op < 2) ? v : 0;
    chk("wb_out_valid", {31'b0, out_valid}, 1);
    chk("out_data", {28'b0, out_data}, r);
    chk("out_rd", {30'b0, out_rd}, rd);
    chk("flag_z", {31'b0, flag_z}, m_z);
    chk("flag_c", {31'b0, flag_c}, m_c);
    chk("flag_v", {31'b0, flag_v}, m_v);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 3'd0; in_rd = 2'd1; in_rs1 = 2'd1; in_imm_en = 1'b1; in_imm = 4'd7;
      @(posedge clk); #1;
      chk("hold_out_valid", {31'b0, out_valid}, 1);
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      chk("hold_out_data", {28'b0, out_data}, r);
      chk("hold_out_rd", {30'b0, out_rd}, rd);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_out_valid", {31'b0, out_valid}, 0);
    chk("idle_in_ready", {31'b0, in_ready}, 1);
    check_regs("wb");
  endtask

  initial begin
    int op, rd, rs1, rs2, ie, imm;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm_en = 1'b0; in_imm = '0; out_ready = 1'b1; dbg_addr = '0;
    for (int k = 0; k < 4; k++) m_reg[k] = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_alu_sel", {29'b0, alu_sel}, 0);
    chk("rst_alu_a", {28'b0, alu_a}, 0);
    chk("rst_out_data", {28'b0, out_data}, 0);
    chk("rst_flags", {29'b0, flag_z, flag_c, flag_v}, 0);
    check_regs("rst");

    do_cmd(0, 1, 0, 0, 1, 5, 0);   // r1 = 5
    do_cmd(0, 2, 1, 0, 1, 3, 0);   // r2 = 8, overflow
    do_cmd(1, 3, 2, 1, 0, 0, 0);   // r3 = 3
    do_cmd(5, 0, 1, 1, 0, 0, 0);   // r0 <- 0, zero flag
    do_cmd(3, 1, 2, 3, 0, 0, 0);   // and clears c/v
    do_cmd(0, 2, 3, 0, 1, 15, 5);  // backpressure, carry out
    do_cmd(0, 1, 0, 0, 1, 14, 0);  // r1 = -2
    do_cmd(6, 2, 1, 0, 1, 3, 0);   // -2 < 3
    do_cmd(7, 3, 1, 1, 0, 0, 0);   // equal

    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(7); rd = $urandom_range(3); rs1 = $urandom_range(3);
      rs2 = $urandom_range(3); ie = $urandom_range(1); imm = $urandom_range(15);
      do_cmd(op, rd, rs1, rs2, ie, imm, $urandom_range(2));
    end

    // asynchronous reset while a command is in EXEC
    in_valid = 1'b1; in_op = 3'd0; in_rd = 2'd3; in_rs1 = 2'd1; in_imm_en = 1'b1; in_imm = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) m_reg[k] = 0;
    chk("arst_out_valid", {31'b0, out_valid}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 1);
    chk("arst_alu", {21'b0, alu_sel, alu_a, alu_b}, 0);
    chk("arst_out", {26'b0, out_data, out_rd}, 0);
    chk("arst_flags", {29'b0, flag_z, flag_c, flag_v}, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_in_ready", {31'b0, in_ready}, 1);
    chk("arst_rel_out_valid", {31'b0, out_valid}, 0);
    check_regs("arst");
    do_cmd(0, 2, 0, 0, 1, 6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
